// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: immediate formats,
// the substitute NOP word and the signed range limits for each format.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } imm_fmt_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0]  F3_SLLI    = 3'b001;
  localparam logic [2:0]  F3_SRXI    = 3'b101;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;

  typedef struct packed {
    imm_fmt_e    imm_src;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field placement and immediate legality check for one request.
// Only the fields the selected format uses reach the output word.
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  enc_req_t    req_i,
  output logic [31:0] instr_o,
  output logic        ok_o
);

  logic signed [31:0] imm_s;
  logic               is_shift;
  logic [31:0]        word;
  logic               ok;

  assign imm_s    = req_i.imm;
  assign is_shift = (req_i.opcode == OPC_OP_IMM) &&
                    ((req_i.funct3 == F3_SLLI) || (req_i.funct3 == F3_SRXI));

  always_comb begin
    word = NOP_INSTR;
    ok   = 1'b0;
    case (req_i.imm_src)
      FMT_I: begin
        if (is_shift) begin
          // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
          ok   = imm_in_range(imm_s, SHAMT_MIN, SHAMT_MAX);
          word = {req_i.funct7, req_i.imm[4:0], req_i.rs1, req_i.funct3,
                  req_i.rd, req_i.opcode};
        end else begin
          ok   = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
          word = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd,
                  req_i.opcode};
        end
      end
      FMT_S: begin
        ok   = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
        word = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                req_i.imm[4:0], req_i.opcode};
      end
      FMT_B: begin
        ok   = imm_in_range(imm_s, IMM13_MIN, IMM13_MAX) && !req_i.imm[0];
        word = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1,
                req_i.funct3, req_i.imm[4:1], req_i.imm[11], req_i.opcode};
      end
      FMT_J: begin
        ok   = imm_in_range(imm_s, IMM21_MIN, IMM21_MAX) && !req_i.imm[0];
        word = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11],
                req_i.imm[19:12], req_i.rd, req_i.opcode};
      end
      FMT_U: begin
        ok   = (req_i.imm[11:0] == 12'h000);
        word = {req_i.imm[31:12], req_i.rd, req_i.opcode};
      end
      default: begin
        ok   = 1'b0;
        word = NOP_INSTR;
      end
    endcase
  end

  assign instr_o = ok ? word : NOP_INSTR;
  assign ok_o    = ok;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: stage 1 captures the request, stage 2 holds
// the packed word with its byte address and error flag until it is consumed.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] err_count
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  enc_req_t    in_req;
  enc_req_t    s1_req_q, s1_req_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] pack_instr;
  logic        pack_ok;
  logic        s1_adv;
  logic        out_fire;

  assign in_req = '{imm_src: imm_fmt_e'(imm_src), opcode: opcode, rd: rd,
                    rs1: rs1, rs2: rs2, funct3: funct3, funct7: funct7,
                    imm: imm};

  instr_encoder_pack u_pack (
    .req_i   (s1_req_q),
    .instr_o (pack_instr),
    .ok_o    (pack_ok)
  );

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    s2_valid_d  = s2_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_req_d = in_req;
    end

    // Stage 2 only reloads when it is empty or its word is leaving this cycle.
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = pack_instr;
        err_d   = !pack_ok;
      end
    end

    if (out_fire) begin
      addr_d = addr_q + STEP;
      if (err_q && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s2_valid_q  <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
      err_count_q <= 16'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s2_valid_q  <= s2_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign out_addr  = addr_q;
  assign err_count = err_count_q;

endmodule
